string_frame_scheduler: RTL and testbench

Shares one first-word-fall-through pixel FIFO read port among N string-group clients, such as multiple extra-string banks. Clients are served one at a time, round-robin. Each grant moves a fixed burst of 24-bit pixels to the granted client. Bursts are separated by a guard gap so each string driver's latch/reset period can start. The block sits between the pixel FIFO and the string-group wrappers.

---
 rtl/string_frame_scheduler_pkg.sv | 29 ++
 rtl/string_frame_scheduler_if.sv | 28 ++
 rtl/string_frame_scheduler_rr_arbiter.sv | 32 +++
 rtl/string_frame_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_string_frame_scheduler.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/string_frame_scheduler_pkg.sv
// Shared types and helpers for the string-group frame scheduler.
package string_sched_pkg;

    localparam int unsigned PIXEL_WIDTH = 24;

    // One LED pixel as it sits in the FIFO (GRB wire order).
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Round-robin search start: client 0 after reset, else the one after the last winner.
    function automatic int unsigned rr_start_idx(input int unsigned last_idx,
                                                 input logic        has_last,
                                                 input int unsigned n_clients);
        if (!has_last) begin
            return 0;
        end
        return (last_idx + 1) % n_clients;
    endfunction

endpackage

// File: rtl/string_frame_scheduler_if.sv
// FIFO-side and client-side signals of the string-group frame scheduler.
// master: the scheduler; slave: FIFO plus string-group wrappers.
interface string_frame_scheduler_if
    import string_sched_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 4
);
    logic                 src_valid;
    pixel_t               src_data;
    logic                 src_pop;
    logic [N_CLIENTS-1:0] req;
    logic [N_CLIENTS-1:0] pix_ready;
    logic [N_CLIENTS-1:0] grant;
    logic                 pix_valid;
    pixel_t               pix_data;
    logic                 burst_done;
    logic                 underrun;

    modport master (
        input  src_valid, src_data, req, pix_ready,
        output src_pop, grant, pix_valid, pix_data, burst_done, underrun
    );

    modport slave (
        output src_valid, src_data, req, pix_ready,
        input  src_pop, grant, pix_valid, pix_data, burst_done, underrun
    );
endinterface

// File: rtl/string_frame_scheduler_rr_arbiter.sv
// Combinational N-way round-robin picker; masked requests never win.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0]         mask_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         winner_c_o,
    output logic [$clog2(N)-1:0] idx_c_o,
    output logic                 any_c_o
);
    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] k_c;

    // Walk the clients starting at ptr_i and take the first eligible one.
    always_comb begin
        winner_c_o = '0;
        idx_c_o    = '0;
        any_c_o    = 1'b0;
        k_c        = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k_c = IDX_W'((32'(ptr_i) + i) % N);
            if (!any_c_o && req_i[k_c] && !mask_i[k_c]) begin
                winner_c_o[k_c] = 1'b1;
                idx_c_o         = k_c;
                any_c_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/string_frame_scheduler.sv
// Shares one FWFT pixel FIFO among N string groups: round-robin fixed-length
// bursts separated by a guard gap, with empty-FIFO abort.
// Optional feature: FRAME_TIMER_EN limits each client to one burst per frame window.
module string_frame_scheduler
    import string_sched_pkg::*;
#(
    parameter int unsigned N_CLIENTS    = 4,
    parameter int unsigned BURST_LEN    = 150,
    parameter int unsigned GAP_CYCLES   = 8,
    parameter int unsigned STALL_LIMIT  = 64
`ifdef FRAME_TIMER_EN
    ,
    parameter int unsigned FRAME_PERIOD = 20000
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    string_frame_scheduler_if.master bus
);
    localparam int unsigned IDX_W   = $clog2(N_CLIENTS);
    localparam int unsigned BC_W    = $clog2(BURST_LEN + 1);
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    state_e               state_q, state_d;
    logic [N_CLIENTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 has_last_q, has_last_d;
    logic [BC_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic                 burst_done_q, burst_done_d;
    logic                 underrun_q, underrun_d;

    logic [N_CLIENTS-1:0] mask_c;
    logic [N_CLIENTS-1:0] arb_winner_c;
    logic [IDX_W-1:0]     arb_idx_c;
    logic                 arb_any_c;
    logic [IDX_W-1:0]     start_c;
    logic                 in_burst_c;
    logic                 xfer_c;

    assign start_c    = IDX_W'(rr_start_idx(32'(last_q), has_last_q, N_CLIENTS));
    assign in_burst_c = (state_q == BURST) && !reset;
    assign xfer_c     = in_burst_c && bus.src_valid && (|(bus.pix_ready & grant_q));

    // FIFO head passes straight through to the granted client.
    assign bus.pix_valid  = in_burst_c && bus.src_valid;
    assign bus.pix_data   = bus.src_data;
    assign bus.src_pop    = xfer_c;
    assign bus.grant      = grant_q;
    assign bus.burst_done = burst_done_q;
    assign bus.underrun   = underrun_q;

    rr_arbiter #(
        .N (N_CLIENTS)
    ) u_arb (
        .req_i      (bus.req),
        .mask_i     (mask_c),
        .ptr_i      (start_c),
        .winner_c_o (arb_winner_c),
        .idx_c_o    (arb_idx_c),
        .any_c_o    (arb_any_c)
    );

`ifdef FRAME_TIMER_EN
    localparam int unsigned FRAME_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    logic [FRAME_W-1:0]   frame_q;
    logic [N_CLIENTS-1:0] served_q;
    logic                 wrap_c;

    assign wrap_c = (frame_q == FRAME_W'(FRAME_PERIOD - 1));
    assign mask_c = served_q;

    // Free-running window timer; a client is marked served when its burst ends or aborts.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q  <= '0;
            served_q <= '0;
        end else begin
            frame_q  <= wrap_c ? '0 : frame_q + FRAME_W'(1);
            served_q <= (wrap_c ? '0 : served_q)
                      | ((burst_done_d || underrun_d) ? grant_q : '0);
        end
    end
`else
    assign mask_c = '0;
`endif

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_q       <= '0;
            has_last_q   <= 1'b0;
            burst_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            burst_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            has_last_q   <= has_last_d;
            burst_cnt_q  <= burst_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            burst_done_q <= burst_done_d;
            underrun_q   <= underrun_d;
        end
    end

    // Next-state: arbitrate in IDLE, count pixels and stalls in BURST, wait out the guard gap.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        has_last_d   = has_last_q;
        burst_cnt_d  = burst_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        burst_done_d = 1'b0;
        underrun_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                gap_cnt_d   = '0;
                stall_cnt_d = '0;
                if (arb_any_c) begin
                    grant_d     = arb_winner_c;
                    last_d      = arb_idx_c;
                    has_last_d  = 1'b1;
                    burst_cnt_d = BC_W'(BURST_LEN);
                    state_d     = BURST;
                end
            end

            BURST: begin
                if (xfer_c && (burst_cnt_q != '0)) begin
                    burst_cnt_d = burst_cnt_q - BC_W'(1);
                end
                if (bus.src_valid) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != STALL_W'(STALL_LIMIT)) begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end

                if (xfer_c && (burst_cnt_q == BC_W'(1))) begin
                    grant_d      = '0;
                    burst_done_d = 1'b1;
                    gap_cnt_d    = '0;
                    state_d      = GAP;
                end else if (!bus.src_valid && (stall_cnt_q >= STALL_W'(STALL_LIMIT - 1))) begin
                    grant_d    = '0;
                    underrun_d = 1'b1;
                    gap_cnt_d  = '0;
                    state_d    = GAP;
                end
            end

            GAP: begin
                stall_cnt_d = '0;
                if (gap_cnt_q != GAP_W'(GAP_CYCLES)) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
                if (gap_cnt_q >= GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_string_frame_scheduler.sv
// Scoreboard bench for string_frame_scheduler (N=4, BURST=4, GAP=2, STALL=3).
`timescale 1ns/1ps
module tb_string_frame_scheduler;
    import string_sched_pkg::*;

    logic clk;
    logic reset;

    string_frame_scheduler_if #(.N_CLIENTS(4)) bus ();

    string_frame_scheduler #(
        .N_CLIENTS    (4),
        .BURST_LEN    (4),
        .GAP_CYCLES   (2),
        .STALL_LIMIT  (3)
`ifdef FRAME_TIMER_EN
        ,
        .FRAME_PERIOD (40)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] head;
    logic [23:0] exp_pix_q[$];
    logic [3:0]  exp_gnt_q[$];
    logic [3:0]  prev_grant = '0;
    int          pops_this = 0;
    int          since_rise = 0;
    int          n_rise = 0;
    int          n_done = 0;
    int          n_under = 0;
    logic        space_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input int budget);
        for (int i = 0; i < budget && bus.grant == 4'b0000; i++) step();
        check_eq({tag, "_grant_seen"}, 32'(bus.grant != 4'b0000), 32'd1);
    endtask

    // Monitor: compares popped pixels and grant order with the queues, checks burst shape.
    always @(negedge clk) begin
        if (reset) begin
            prev_grant = '0;
            pops_this  = 0;
        end else begin
            since_rise++;
            if (bus.grant != 4'b0000 && prev_grant == 4'b0000) begin
                n_rise++;
                if (exp_gnt_q.size() > 0) check_eq("grant_order", 32'(bus.grant), 32'(exp_gnt_q.pop_front()));
                else check_eq("grant_unexpected", 32'(bus.grant), 32'd0);
                if (space_en && n_rise > 1) check_eq("grant_spacing", 32'(since_rise), 32'd7);
                since_rise = 0;
                pops_this  = 0;
            end
            if (bus.src_pop) begin
                check_eq("pop_needs_valid", 32'(bus.src_valid), 32'd1);
                check_eq("pop_needs_granted_ready", 32'(|(bus.pix_ready & bus.grant)), 32'd1);
                check_eq("pix_data", 32'(bus.pix_data), 32'(exp_pix_q.pop_front()));
                pops_this++;
                head = head + 24'h010101;
                bus.src_data = head;
                exp_pix_q.push_back(head);
            end
            if (bus.burst_done) begin
                n_done++;
                check_eq("done_pops", 32'(pops_this), 32'd4);
                check_eq("done_grant_clear", 32'(bus.grant), 32'd0);
            end
            if (bus.underrun) n_under++;
            prev_grant = bus.grant;
        end
    end

    initial begin
        int base;
        int t;
        head = 24'hA00001;
        bus.src_data  = head;
        exp_pix_q.push_back(head);
        bus.src_valid = 1'b1;
        bus.req       = 4'b1111;
        bus.pix_ready = 4'b1111;
        reset         = 1'b1;

        // Reset held with everything requesting: nothing may move.
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_grant", 32'(bus.grant), 32'd0);
            check_eq("rst_src_pop", 32'(bus.src_pop), 32'd0);
            check_eq("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        end

        // Round-robin at full throughput.
        exp_gnt_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        space_en  = 1'b1;
        reset     = 1'b0;
        step();
        check_eq("grant_after_release", 32'(bus.grant), 32'h1);
        for (int i = 0; i < 60 && exp_gnt_q.size() > 0; i++) step();
        check_eq("rr_all_grants", 32'(exp_gnt_q.size()), 32'd0);
        bus.req = 4'b0000;
        repeat (10) step();
        check_eq("rr_dones", 32'(n_done), 32'd5);
        space_en = 1'b0;

        // Backpressure: only the granted client's ready matters.
        exp_gnt_q.push_back(4'b0010);
        bus.req       = 4'b0010;
        bus.pix_ready = 4'b1101;
        wait_grant("bp", 20);
        bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_foreign_ready_no_pop", 32'(bus.src_pop), 32'd0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            bus.pix_ready = (i % 2 == 0) ? 4'b1111 : 4'b1101;
            #1;
            check_eq("bp_pop_follows_ready", 32'(bus.src_pop), 32'((i % 2) == 0));
            step();
        end
        bus.pix_ready = 4'b1111;
        check_eq("bp_done", 32'(n_done), 32'd6);
        repeat (4) step();

        // Underrun after two transfers, then the next client is served.
        exp_gnt_q.push_back(4'b0100);
        bus.req = 4'b0100;
        wait_grant("ur", 20);
        bus.req = 4'b0000;
        step();
        step();
        bus.src_valid = 1'b0;
        step();
        step();
        check_eq("ur_not_yet", 32'(bus.underrun), 32'd0);
        check_eq("ur_grant_held", 32'(bus.grant), 32'h4);
        step();
        check_eq("ur_pulse", 32'(bus.underrun), 32'd1);
        check_eq("ur_grant_clear", 32'(bus.grant), 32'd0);
        check_eq("ur_no_done", 32'(bus.burst_done), 32'd0);
        bus.src_valid = 1'b1;
        step();
        check_eq("ur_one_cycle", 32'(bus.underrun), 32'd0);
        exp_gnt_q.push_back(4'b1000);
        bus.req = 4'b1100;
        wait_grant("ur_next", 20);
        bus.req = 4'b0000;
        repeat (8) step();
        check_eq("ur_count", 32'(n_under), 32'd1);
        check_eq("ur_dones", 32'(n_done), 32'd7);

        // Reset mid-burst: pop is blocked in the reset cycle, pointer restarts.
        exp_gnt_q.push_back(4'b0001);
        bus.req = 4'b0001;
        wait_grant("rb", 20);
        step();
        step();
        reset = 1'b1;
        #1;
        check_eq("rb_pop_in_reset", 32'(bus.src_pop), 32'd0);
        step();
        check_eq("rb_grant_cleared", 32'(bus.grant), 32'd0);
        reset = 1'b0;
        exp_gnt_q.push_back(4'b0001);
        bus.req = 4'b1111;
        wait_grant("rb_restart", 20);
        bus.req = 4'b0000;
        repeat (8) step();
        check_eq("rb_dones", 32'(n_done), 32'd8);

`ifdef FRAME_TIMER_EN
        // One burst per client per 40-cycle window.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        base  = n_rise;
        exp_gnt_q = '{4'b0001, 4'b0010, 4'b0001};
        bus.req = 4'b0011;
        t = 0;
        for (int i = 0; i < 100 && n_rise < base + 3; i++) begin
            step();
            t++;
        end
        check_eq("frame_third_grant", 32'(n_rise - base), 32'd3);
        check_eq("frame_held_until_wrap", 32'(t >= 30), 32'd1);
        bus.req = 4'b0000;
        repeat (8) step();
`else
        base = 0;
        t    = 0;
`endif

        check_eq("grants_pending", 32'(exp_gnt_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
